// File: rtl/rom_download_buffer.sv
// rom_download_buffer
// Elastic first-word-fall-through buffer between the hps_io ROM download
// port and the core download interface, all in the clk_sys domain.
// It absorbs HPS write bursts while the core's memory path stalls and
// back-pressures the HPS through ioctl_wait. A chip-select window frames
// each download, and completion, word count and overflow are reported.

module rom_download_buffer #(
    parameter int DEPTH        = 8,
    parameter int ADDR_WIDTH   = 25,
    parameter int DATA_WIDTH   = 16,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    // HPS side
    input  logic                  ioctl_download,
    input  logic                  ioctl_wr,
    input  logic [ADDR_WIDTH-1:0] ioctl_addr,
    input  logic [DATA_WIDTH-1:0] ioctl_dout,
    output logic                  ioctl_wait,
    // core side
    output logic                  dl_cs,
    output logic                  dl_wr,
    output logic [ADDR_WIDTH-1:0] dl_addr,
    output logic [DATA_WIDTH-1:0] dl_dout,
    input  logic                  dl_wait_req,
    output logic                  dl_done,
    output logic [ADDR_WIDTH-1:0] dl_count,
    output logic                  dl_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] WAIT_LVL = LW'(DEPTH - AFULL_MARGIN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // storage and bookkeeping
    logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [LW-1:0]         level, level_nxt;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0] hold_data;

    logic empty, full;
    logic accepting;   // pushes are only taken in ACTIVE
    logic window;      // ACTIVE or DRAIN; drives dl_cs
    logic start;       // edge that opens a new download: clear stats
    logic push_req, push, drop, pop;
    logic wait_nxt;

    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);

    // Core-facing handshake: head is presented whenever the window is open
    // and something is buffered; the core takes it when not stalling.
    assign dl_wr = ~empty & window;
    assign pop   = dl_wr & ~dl_wait_req;

    // A push into a full FIFO still succeeds if the head leaves this cycle.
    assign push_req = accepting & ioctl_wr;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    // Level after this edge, used for the drain exit and for ioctl_wait.
    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // FSM next-state logic; start marks the edge that begins a download
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            S_IDLE: begin
                if (ioctl_download) begin
                    state_nxt = S_ACTIVE;
                    start     = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (!ioctl_download) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (level_nxt == '0) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (ioctl_download) begin
                    state_nxt = S_ACTIVE;
                    start     = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs, decoded from the registered state only
    always_comb begin
        accepting = 1'b0;
        window    = 1'b0;
        dl_done   = 1'b0;
        case (state)
            S_ACTIVE: begin
                accepting = 1'b1;
                window    = 1'b1;
            end
            S_DRAIN:  window  = 1'b1;
            S_DONE:   dl_done = 1'b1;
            default: ;
        endcase
    end

    assign dl_cs = window;

    // FIFO storage; contents need no reset since level gates visibility
    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem_addr[wptr] <= ioctl_addr;
            mem_data[wptr] <= ioctl_dout;
        end
    end

    // Pointers and fill level
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            level <= level_nxt;
        end
    end

    // Remember the last presented head so the outputs hold while idle
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hold_addr <= '0;
            hold_data <= '0;
        end else if (dl_wr) begin
            hold_addr <= mem_addr[rptr];
            hold_data <= mem_data[rptr];
        end
    end

    assign dl_addr = dl_wr ? mem_addr[rptr] : hold_addr;
    assign dl_dout = dl_wr ? mem_data[rptr] : hold_data;

    // Per-download statistics: delivered words and sticky drop flag
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dl_count    <= '0;
            dl_overflow <= 1'b0;
        end else if (start) begin
            dl_count    <= '0;
            dl_overflow <= 1'b0;
        end else begin
            if (pop)  dl_count    <= dl_count + ADDR_WIDTH'(1);
            if (drop) dl_overflow <= 1'b1;
        end
    end

    // Back-pressure from the post-edge level; quiet outside the window
    assign wait_nxt = ((state_nxt == S_ACTIVE) || (state_nxt == S_DRAIN)) &&
                      (level_nxt >= WAIT_LVL);

    // Registered back-pressure to the HPS
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) ioctl_wait <= 1'b0;
        else          ioctl_wait <= wait_nxt;
    end

endmodule

// File: tb/tb_rom_download_buffer.sv
// Directed bench for rom_download_buffer: a vector table for a plain
// download, then hand-written sequences for stall, overflow, full-with-pop,
// drain with toggling stall and async reset during drain.

module tb_rom_download_buffer;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [15:0] ioctl_dout = '0;
    logic        ioctl_wait;
    logic        dl_cs, dl_wr, dl_done, dl_overflow;
    logic [24:0] dl_addr, dl_count;
    logic [15:0] dl_dout;
    logic        dl_wait_req = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    rom_download_buffer dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .dl_cs          (dl_cs),
        .dl_wr          (dl_wr),
        .dl_addr        (dl_addr),
        .dl_dout        (dl_dout),
        .dl_wait_req    (dl_wait_req),
        .dl_done        (dl_done),
        .dl_count       (dl_count),
        .dl_overflow    (dl_overflow)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        dl, wr;
        logic [24:0] a;
        logic [15:0] d;
        logic        wq;
        logic        e_wait, e_cs, e_wr;
        logic [24:0] e_addr;
        logic [15:0] e_dout;
        logic        e_done;
        logic [24:0] e_count;
        logic        e_ovf;
    } vec_t;

    function automatic vec_t mk(input logic dl, wr, input logic [24:0] a,
                                input logic [15:0] d, input logic wq,
                                input logic e_wait, e_cs, e_wr,
                                input logic [24:0] e_addr, input logic [15:0] e_dout,
                                input logic e_done, input logic [24:0] e_count,
                                input logic e_ovf);
        vec_t v;
        v.dl = dl; v.wr = wr; v.a = a; v.d = d; v.wq = wq;
        v.e_wait = e_wait; v.e_cs = e_cs; v.e_wr = e_wr;
        v.e_addr = e_addr; v.e_dout = e_dout; v.e_done = e_done;
        v.e_count = e_count; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // drive on the falling edge, return just after the next rising edge
    task automatic step(input logic dl, wr, input logic [24:0] a,
                        input logic [15:0] d, input logic wq);
        @(negedge clk_sys);
        ioctl_download = dl;
        ioctl_wr       = wr;
        ioctl_addr     = a;
        ioctl_dout     = d;
        dl_wait_req    = wq;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk_head(input string nm, input logic [24:0] a, input logic [15:0] d);
        chk({nm, ".addr"}, 32'(dl_addr), 32'(a));
        chk({nm, ".dout"}, 32'(dl_dout), 32'(d));
    endtask

    vec_t tv [8];
    int   popped;

    initial begin
        // plain download, no stall
        tv[0] = mk(1,0,25'h0,16'h0000,0,  0,1,0,25'h0,16'h0000,0,25'd0,0);
        tv[1] = mk(1,1,25'h0,16'h1111,0,  0,1,1,25'h0,16'h1111,0,25'd0,0);
        tv[2] = mk(1,1,25'h2,16'h2222,0,  0,1,1,25'h2,16'h2222,0,25'd1,0);
        tv[3] = mk(1,1,25'h4,16'h3333,0,  0,1,1,25'h4,16'h3333,0,25'd2,0);
        tv[4] = mk(1,1,25'h6,16'h4444,0,  0,1,1,25'h6,16'h4444,0,25'd3,0);
        tv[5] = mk(0,0,25'h0,16'h0000,0,  0,1,0,25'h6,16'h4444,0,25'd4,0);
        tv[6] = mk(0,0,25'h0,16'h0000,0,  0,0,0,25'h6,16'h4444,1,25'd4,0);
        tv[7] = mk(0,0,25'h0,16'h0000,0,  0,0,0,25'h6,16'h4444,0,25'd4,0);

        // reset state
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst.cs",    32'(dl_cs), 0);
        chk("rst.wr",    32'(dl_wr), 0);
        chk("rst.wait",  32'(ioctl_wait), 0);
        chk("rst.done",  32'(dl_done), 0);
        chk("rst.count", 32'(dl_count), 0);
        chk("rst.ovf",   32'(dl_overflow), 0);
        chk_head("rst", 25'h0, 16'h0);
        @(negedge clk_sys);
        reset_n = 1'b1;

        // table: basic 4-word download
        for (int i = 0; i < 8; i++) begin
            step(tv[i].dl, tv[i].wr, tv[i].a, tv[i].d, tv[i].wq);
            chk($sformatf("t1[%0d].wait", i),  32'(ioctl_wait),  32'(tv[i].e_wait));
            chk($sformatf("t1[%0d].cs", i),    32'(dl_cs),       32'(tv[i].e_cs));
            chk($sformatf("t1[%0d].wr", i),    32'(dl_wr),       32'(tv[i].e_wr));
            chk($sformatf("t1[%0d].addr", i),  32'(dl_addr),     32'(tv[i].e_addr));
            chk($sformatf("t1[%0d].dout", i),  32'(dl_dout),     32'(tv[i].e_dout));
            chk($sformatf("t1[%0d].done", i),  32'(dl_done),     32'(tv[i].e_done));
            chk($sformatf("t1[%0d].count", i), 32'(dl_count),    32'(tv[i].e_count));
            chk($sformatf("t1[%0d].ovf", i),   32'(dl_overflow), 32'(tv[i].e_ovf));
        end

        // stall, ioctl_wait threshold at 6, stable head, in-order drain
        step(1, 0, 25'h0, 16'h0, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 25'h100 + 25'(2 * i), 16'hA000 + 16'(i), 1);
            chk_head("t2.stall", 25'h100, 16'hA000);
            chk($sformatf("t2.wait%0d", i), 32'(ioctl_wait), (i == 5) ? 32'd1 : 32'd0);
        end
        for (int j = 1; j <= 6; j++) begin
            step(1, 0, 25'h0, 16'h0, 0);
            chk("t2.wait_rel", 32'(ioctl_wait), 0);
            if (j < 6) chk_head($sformatf("t2.pop%0d", j), 25'h100 + 25'(2 * j), 16'hA000 + 16'(j));
            else       chk("t2.empty", 32'(dl_wr), 0);
        end
        step(0, 0, 25'h0, 16'h0, 0);
        step(0, 0, 25'h0, 16'h0, 0);
        chk("t2.done",  32'(dl_done), 1);
        chk("t2.count", 32'(dl_count), 6);
        step(0, 0, 25'h0, 16'h0, 0);
        chk("t2.idle_done", 32'(dl_done), 0);

        // overflow: 9 pushes into 8 entries while stalled
        step(1, 0, 25'h0, 16'h0, 1);
        chk("t3.count_clr", 32'(dl_count), 0);
        for (int i = 0; i < 9; i++) begin
            step(1, 1, 25'h200 + 25'(2 * i), 16'hB000 + 16'(i), 1);
            if (i == 7) chk("t3.ovf_pre", 32'(dl_overflow), 0);
            if (i == 8) begin
                chk("t3.ovf", 32'(dl_overflow), 1);
                chk("t3.wait", 32'(ioctl_wait), 1);
            end
        end
        for (int i = 0; i < 8; i++) begin
            chk("t3.wr", 32'(dl_wr), 1);
            chk_head($sformatf("t3.word%0d", i), 25'h200 + 25'(2 * i), 16'hB000 + 16'(i));
            step(0, 0, 25'h0, 16'h0, 0);
        end
        chk("t3.done",  32'(dl_done), 1);
        chk("t3.count", 32'(dl_count), 8);
        step(0, 0, 25'h0, 16'h0, 0);
        chk("t3.ovf_sticky", 32'(dl_overflow), 1);

        // full with simultaneous push and pop: nothing dropped
        step(1, 0, 25'h0, 16'h0, 1);
        chk("t4.ovf_clr", 32'(dl_overflow), 0);
        for (int i = 0; i < 8; i++)
            step(1, 1, 25'h300 + 25'(2 * i), 16'hC000 + 16'(i), 1);
        chk("t4.wait_full", 32'(ioctl_wait), 1);
        for (int i = 0; i < 4; i++) begin
            chk_head($sformatf("t4.word%0d", i), 25'h300 + 25'(2 * i), 16'hC000 + 16'(i));
            step(1, 1, 25'h300 + 25'(2 * (8 + i)), 16'hC000 + 16'(8 + i), 0);
            chk("t4.wait", 32'(ioctl_wait), 1);
            chk("t4.ovf",  32'(dl_overflow), 0);
        end
        for (int i = 4; i < 12; i++) begin
            chk_head($sformatf("t4.word%0d", i), 25'h300 + 25'(2 * i), 16'hC000 + 16'(i));
            step(0, 0, 25'h0, 16'h0, 0);
        end
        chk("t4.done",  32'(dl_done), 1);
        chk("t4.count", 32'(dl_count), 12);
        chk("t4.ovf_end", 32'(dl_overflow), 0);
        step(0, 0, 25'h0, 16'h0, 0);

        // drain with toggling stall and a late write that must be ignored
        step(1, 0, 25'h0, 16'h0, 1);
        for (int i = 0; i < 5; i++)
            step(1, 1, 25'h400 + 25'(2 * i), 16'hD000 + 16'(i), 1);
        step(0, 0, 25'h0, 16'h0, 1);
        chk("t5.cs_drain", 32'(dl_cs), 1);
        popped = 0;
        for (int j = 0; j < 20 && popped < 5; j++) begin
            chk("t5.cs",   32'(dl_cs), 1);
            chk("t5.done_early", 32'(dl_done), 0);
            chk_head($sformatf("t5.word%0d", popped), 25'h400 + 25'(2 * popped), 16'hD000 + 16'(popped));
            step(0, (j == 1), 25'h3FE, 16'hDEAD, j[0]);
            if (!j[0]) popped++;
        end
        chk("t5.popped", 32'(popped), 5);
        chk("t5.done",  32'(dl_done), 1);
        chk("t5.cs_off", 32'(dl_cs), 0);
        chk("t5.count", 32'(dl_count), 5);
        step(0, 0, 25'h0, 16'h0, 0);

        // async reset in the middle of a drain
        step(1, 0, 25'h0, 16'h0, 1);
        for (int i = 0; i < 4; i++)
            step(1, 1, 25'h500 + 25'(2 * i), 16'hE000 + 16'(i), 1);
        step(1, 0, 25'h0, 16'h0, 0);
        chk("t6.count1", 32'(dl_count), 1);
        step(0, 0, 25'h0, 16'h0, 1);
        chk("t6.cs_drain", 32'(dl_cs), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6.cs",    32'(dl_cs), 0);
        chk("t6.wr",    32'(dl_wr), 0);
        chk("t6.wait",  32'(ioctl_wait), 0);
        chk("t6.done",  32'(dl_done), 0);
        chk("t6.count", 32'(dl_count), 0);
        chk("t6.ovf",   32'(dl_overflow), 0);
        chk_head("t6.rst", 25'h0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 25'h0, 16'h0, 0);
            chk("t6.no_done", 32'(dl_done), 0);
        end
        @(negedge clk_sys);
        reset_n = 1'b1;
        step(1, 0, 25'h0, 16'h0, 0);
        chk("t6.restart_cs", 32'(dl_cs), 1);
        chk("t6.restart_wr", 32'(dl_wr), 0);
        chk("t6.restart_cnt", 32'(dl_count), 0);
        step(1, 1, 25'h0F0, 16'h5A5A, 0);
        chk("t6.new_wr", 32'(dl_wr), 1);
        chk_head("t6.new", 25'h0F0, 16'h5A5A);
        step(0, 0, 25'h0, 16'h0, 0);
        step(0, 0, 25'h0, 16'h0, 0);
        chk("t6.new_done",  32'(dl_done), 1);
        chk("t6.new_count", 32'(dl_count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
